fetch_stage: RTL and testbench

- Instruction fetch front end sitting directly upstream of the decode/execute core; it produces the instruction stream that core consumes.
- Owns the fetch PC and issues reads to a synchronous instruction memory with a fixed 1-cycle read latency.
- Buffers returned instructions with their PCs in a small prefetch queue and hands them downstream over a valid/ready handshake.
- Accepts a redirect, which flushes all queued and in-flight fetches.

---
 rtl/fetch_stage.sv | 103 ++++++++++
 tb/tb_fetch_stage.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch front end: owns the fetch PC, reads a 1-cycle-latency instruction
// memory and buffers {pc, instr} pairs in a prefetch queue. Optional FETCH_STATS_EN adds bubble_cycles.
module fetch_stage #(
  parameter int unsigned          ADDR_W      = 8,
  parameter int unsigned          INSTR_W     = 8,
  parameter int unsigned          QUEUE_DEPTH = 4,
  parameter logic [ADDR_W-1:0]    RESET_PC    = '0,
  localparam int unsigned         CW          = $clog2(QUEUE_DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [CW-1:0]      queue_count
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0]        bubble_cycles
`endif
);

  localparam int unsigned PW = $clog2(QUEUE_DEPTH);

  logic [ADDR_W-1:0]  fetch_pc;
  logic               inflight;
  logic [ADDR_W-1:0]  inflight_pc;
  logic [INSTR_W-1:0] instr_q [QUEUE_DEPTH];
  logic [ADDR_W-1:0]  pc_q    [QUEUE_DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  logic [CW:0]        occupancy;
  logic               push;
  logic               pop;

  // Downstream handshake: out_valid/out_instr/out_pc are stable until the cycle
  // out_valid && out_ready, which is the single pop point. A redirect hides the head.
  assign occupancy = {1'b0, count} + (CW+1)'(inflight);
  assign imem_req  = !rst && !redirect_valid && (occupancy < (CW+1)'(QUEUE_DEPTH));
  assign imem_addr = fetch_pc;
  assign push      = inflight && !rst && !redirect_valid;
  assign out_valid = (count != '0) && !redirect_valid;
  assign pop       = out_valid && out_ready;

  assign out_instr   = out_valid ? instr_q[rd_ptr] : '0;
  assign out_pc      = out_valid ? pc_q[rd_ptr]    : '0;
  assign queue_count = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else if (redirect_valid) begin
      fetch_pc    <= redirect_pc;
      inflight    <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        fetch_pc    <= fetch_pc + 1'b1;
        inflight_pc <= fetch_pc;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Slot reservation for the in-flight read guarantees push never hits a full queue.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_q[wr_ptr] <= imem_rdata;
      pc_q[wr_ptr]    <= inflight_pc;
    end
  end

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cycles <= '0;
    end else if (!out_valid && (bubble_cycles != 16'hFFFF)) begin
      bubble_cycles <= bubble_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios push expected {pc, instr} pairs,
// a negedge monitor pops and compares on every accepted handshake.
module tb_fetch_stage;

  localparam int W = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic [7:0] imem_rdata = '0;
  logic       redirect_valid = 1'b0;
  logic [7:0] redirect_pc = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_instr;
  logic [7:0] out_pc;
  logic [2:0] queue_count;
`ifdef FETCH_STATS_EN
  logic [15:0] bubble_cycles;
`endif

  logic [W-1:0] exp_q[$];
  int tests_run = 0;
  int tests_failed = 0;

  fetch_stage dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .queue_count(queue_count)
`ifdef FETCH_STATS_EN
    , .bubble_cycles(bubble_cycles)
`endif
  );

  // ---------------- clock / memory model ----------------
  always #5 clk = ~clk;

  // Memory image: addr 0 -> 0x11, 1 -> 0x22, 2 -> 0x33, ... (8-bit wrap)
  function automatic logic [7:0] instr_of(input logic [7:0] a);
    logic [7:0] r;
    r = a + 8'd1;
    return r * 8'd17;
  endfunction

  always @(posedge clk) if (imem_req) imem_rdata <= instr_of(imem_addr);

  // ---------------- driver / check tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] pc);
    exp_q.push_back({pc, instr_of(pc)});
  endtask

  task automatic do_reset(input logic ready);
    rst = 1'b1;
    redirect_valid = 1'b0;
    out_ready = ready;
    repeat (2) next_cycle();
    @(negedge clk);
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_queue_count", 32'(queue_count), 32'd0);
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic drain_check(input string name);
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", {16'd0, out_pc, out_instr}, 32'hFFFF_FFFF);
      end else begin
        check("stream", 32'({out_pc, out_instr}), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int req_n;
    logic [7:0] last_addr;

    // T1: stream from reset, no bubbles
    do_reset(1'b1);
    for (int i = 0; i < 5; i++) push_exp(8'(i));
    for (int c = 0; c < 8; c++) begin
      if (c == 7) out_ready = 1'b0;
      @(negedge clk);
      if (c == 0) begin
        check("t1_c0_req", 32'(imem_req), 32'd1);
        check("t1_c0_addr", 32'(imem_addr), 32'h00);
      end
      if (c == 1) check("t1_c1_valid", 32'(out_valid), 32'd0);
      if (c == 2) begin
        check("t1_c2_pc", 32'(out_pc), 32'h00);
        check("t1_c2_instr", 32'(out_instr), 32'h11);
      end
      if (c >= 2 && c <= 6) check("t1_no_bubble", 32'(out_valid), 32'd1);
      next_cycle();
    end
    drain_check("t1_drain");

    // T2: back-pressure from reset, then release
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) push_exp(8'(i));
    req_n = 0;
    last_addr = '0;
    for (int c = 0; c < 17; c++) begin
      if (c == 11) out_ready = 1'b1;
      if (c == 16) out_ready = 1'b0;
      @(negedge clk);
      if (c <= 10 && imem_req) begin
        req_n++;
        last_addr = imem_addr;
      end
      if (c == 5) check("t2_hold_instr", 32'(out_instr), 32'h11);
      if (c == 10) begin
        check("t2_req_count", 32'(req_n), 32'd4);
        check("t2_last_addr", 32'(last_addr), 32'h03);
        check("t2_queue_count", 32'(queue_count), 32'd4);
        check("t2_valid", 32'(out_valid), 32'd1);
        check("t2_hold_instr2", 32'(out_instr), 32'h11);
        check("t2_hold_pc", 32'(out_pc), 32'h00);
      end
      next_cycle();
    end
    drain_check("t2_drain");

    // T3: redirect to 0x40 with a read in flight
    do_reset(1'b1);
    for (int i = 0; i < 3; i++) push_exp(8'(i));
    for (int i = 0; i < 3; i++) push_exp(8'(8'h40 + i));
    for (int c = 0; c < 12; c++) begin
      if (c == 5) begin
        redirect_valid = 1'b1;
        redirect_pc = 8'h40;
      end
      if (c == 6) redirect_valid = 1'b0;
      if (c == 11) out_ready = 1'b0;
      @(negedge clk);
`ifdef FETCH_STATS_EN
      if (c == 4) check("t3_bubbles_stream", 32'(bubble_cycles), 32'd2);
      if (c == 8) check("t3_bubbles_redirect", 32'(bubble_cycles), 32'd5);
`endif
      if (c == 5) begin
        check("t3_redir_valid", 32'(out_valid), 32'd0);
        check("t3_redir_req", 32'(imem_req), 32'd0);
      end
      if (c == 6) begin
        check("t3_flush_count", 32'(queue_count), 32'd0);
        check("t3_new_req", 32'(imem_req), 32'd1);
        check("t3_new_addr", 32'(imem_addr), 32'h40);
      end
      if (c == 7) check("t3_c7_valid", 32'(out_valid), 32'd0);
      if (c == 8) begin
        check("t3_c8_valid", 32'(out_valid), 32'd1);
        check("t3_c8_pc", 32'(out_pc), 32'h40);
      end
      next_cycle();
    end
    drain_check("t3_drain");

    // T4: redirect near the top of the address space wraps the PC
    do_reset(1'b1);
    push_exp(8'hFE);
    push_exp(8'hFF);
    push_exp(8'h00);
    push_exp(8'h01);
    for (int c = 0; c < 8; c++) begin
      if (c == 0) begin
        redirect_valid = 1'b1;
        redirect_pc = 8'hFE;
      end
      if (c == 1) redirect_valid = 1'b0;
      if (c == 7) out_ready = 1'b0;
      @(negedge clk);
      if (c == 0) check("t4_redir_req", 32'(imem_req), 32'd0);
      if (c == 1) check("t4_addr_fe", 32'(imem_addr), 32'hFE);
      if (c == 3) begin
        check("t4_addr_wrap", 32'(imem_addr), 32'h00);
        check("t4_first_pc", 32'(out_pc), 32'hFE);
      end
      next_cycle();
    end
    drain_check("t4_drain");

    // T5: one-cycle reset with 3 queued entries and a read in flight
    do_reset(1'b0);
    push_exp(8'h00);
    push_exp(8'h01);
    for (int c = 0; c < 10; c++) begin
      if (c == 4) rst = 1'b1;
      if (c == 5) rst = 1'b0;
      if (c == 7) out_ready = 1'b1;
      if (c == 9) out_ready = 1'b0;
      @(negedge clk);
      if (c == 4) check("t5_pre_count", 32'(queue_count), 32'd3);
      if (c == 5) begin
        check("t5_valid", 32'(out_valid), 32'd0);
        check("t5_count", 32'(queue_count), 32'd0);
        check("t5_addr", 32'(imem_addr), 32'h00);
        check("t5_req", 32'(imem_req), 32'd1);
      end
      if (c == 6) check("t5_stale_dropped", 32'(queue_count), 32'd0);
      next_cycle();
    end
    drain_check("t5_drain");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
